// File: rtl/imm_gen_pkg.sv
// Shared opcode, funct3 and format definitions for the immediate stage.
// IMM_GEN_ILLEGAL_DETECT_EN enables the opcode legality helper's use.
package imm_gen_pkg;

  localparam logic [6:0] OPC_ARITH     = 7'b0110011;
  localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_ECALL     = 7'b1110011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

  function automatic logic known_opc(input logic [6:0] opc);
    return opc inside {OPC_ARITH, OPC_ARITH_IMM, OPC_LOAD,
                       OPC_JALR, OPC_STORE, OPC_BRANCH,
                       OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_ECALL};
  endfunction

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational instruction -> {immediate, format, illegal} decoder.
// Illegal flagging only exists with IMM_GEN_ILLEGAL_DETECT_EN.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic is_shift, is_i, is_s, is_b, is_u, is_j;

  logic signed [11:0] i_imm;
  logic signed [11:0] s_imm;
  logic signed [12:0] b_imm;
  logic signed [31:0] u_imm;
  logic signed [20:0] j_imm;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];

  assign is_shift = (opc == OPC_ARITH_IMM) &&
                    (f3 == F3_SLL || f3 == F3_SRL_SRA);
  assign is_i = (opc == OPC_ARITH_IMM && !is_shift) ||
                opc == OPC_LOAD || opc == OPC_JALR;
  assign is_s = opc == OPC_STORE;
  assign is_b = opc == OPC_BRANCH;
  assign is_u = opc == OPC_LUI || opc == OPC_AUIPC;
  assign is_j = opc == OPC_JAL;

  assign i_imm = inst_i[31:20];
  assign s_imm = {inst_i[31:25], inst_i[11:7]};
  assign b_imm = {inst_i[31], inst_i[7], inst_i[30:25],
                  inst_i[11:8], 1'b0};
  assign u_imm = {inst_i[31:12], 12'b0};
  assign j_imm = {inst_i[31], inst_i[19:12], inst_i[20],
                  inst_i[30:21], 1'b0};

  always_comb begin
    imm_o = '0;
    fmt_o = FMT_NONE;
    unique case (1'b1)
      is_shift: begin
        imm_o = XLEN'(inst_i[SHAMT_W+19:20]);
        fmt_o = FMT_SHAMT;
      end
      is_i: begin
        imm_o = XLEN'(i_imm);
        fmt_o = FMT_I;
      end
      is_s: begin
        imm_o = XLEN'(s_imm);
        fmt_o = FMT_S;
      end
      is_b: begin
        imm_o = XLEN'(b_imm);
        fmt_o = FMT_B;
      end
      is_u: begin
        imm_o = XLEN'(u_imm);
        fmt_o = FMT_U;
      end
      is_j: begin
        imm_o = XLEN'(j_imm);
        fmt_o = FMT_J;
      end
      default: ;
    endcase
  end

`ifdef IMM_GEN_ILLEGAL_DETECT_EN
  // RV32 has no 6-bit shift amount, so inst[25] set is reserved there.
  assign illegal_o = !known_opc(opc) ||
                     (XLEN == 32 && is_shift && inst_i[25]);
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate stage: decode, PC+imm target, 2-entry skid, flush.
// Optional IMM_GEN_ILLEGAL_DETECT_EN drives out_illegal.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic            ill;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;
  entry_t          dec;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic   rdy_q, accept, xfer;

  imm_decode_comb #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_dec (
    .inst_i    (in_inst),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_ill)
  );

  assign dec = '{imm: dec_imm, fmt: dec_fmt, pc: in_pc,
                 tgt: in_pc + dec_imm, ill: dec_ill};

  assign accept = in_valid && rdy_q;
  assign xfer   = main_v_q && out_ready;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || xfer) begin
      // Skid is never full while ready is high, so no accept competes here.
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d   = dec;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= !skid_v_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = main_v_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_pc      = main_q.pc;
  assign out_target  = main_q.tgt;
  assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Randomised + directed bench for imm_gen_stage at XLEN 32 and 64.
// Queue-level reference model of the decode rules and 2-deep buffering.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc32;
  logic [63:0] in_pc64;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32, pc32, tgt32;
  logic [2:0]  fmt32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64, pc64, tgt64;
  logic [2:0]  fmt64;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_pc(in_pc32),
    .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_pc(pc32),
    .out_target(tgt32), .out_illegal(ill32)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_pc(in_pc64),
    .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_pc(pc64),
    .out_target(tgt64), .out_illegal(ill64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  logic ready_m;

`ifdef IMM_GEN_ILLEGAL_DETECT_EN
  localparam logic ILL_ON = 1'b1;
`else
  localparam logic ILL_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_dec(input logic [31:0] ins,
                                   input logic [63:0] pc,
                                   input bit x64);
    exp_t e;
    longint v;
    logic [2:0] f;
    logic ill;
    v = 0;
    f = 3'd0;
    ill = 1'b0;
    case (ins[6:0])
      7'h13: begin
        if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) begin
          f = 3'd6;
          if (x64) v = longint'(ins[25:20]);
          else v = longint'(ins[24:20]);
          ill = !x64 && ins[25];
        end else begin
          f = 3'd1;
          v = longint'($signed(ins[31:20]));
        end
      end
      7'h03, 7'h67: begin
        f = 3'd1;
        v = longint'($signed(ins[31:20]));
      end
      7'h23: begin
        f = 3'd2;
        v = longint'($signed({ins[31:25], ins[11:7]}));
      end
      7'h63: begin
        f = 3'd3;
        v = longint'($signed({ins[31], ins[7], ins[30:25],
                              ins[11:8]})) * 2;
      end
      7'h37, 7'h17: begin
        f = 3'd4;
        v = longint'($signed(ins[31:12])) * 4096;
      end
      7'h6F: begin
        f = 3'd5;
        v = longint'($signed({ins[31], ins[19:12], ins[20],
                              ins[30:21]})) * 2;
      end
      7'h33, 7'h73: ;
      default: ill = 1'b1;
    endcase
    e.fmt = f;
    e.ill = ill && ILL_ON;
    if (x64) begin
      e.imm = v;
      e.pc  = pc;
      e.tgt = pc + v;
    end else begin
      e.imm = {32'h0, v[31:0]};
      e.pc  = {32'h0, pc[31:0]};
      e.tgt = {32'h0, pc[31:0] + v[31:0]};
    end
    return e;
  endfunction

  task automatic check_outs();
    exp_t e;
    check("in_ready32", 64'(rdy32), 64'(ready_m));
    check("in_ready64", 64'(rdy64), 64'(ready_m));
    check("out_valid32", 64'(ov32), 64'(q32.size() > 0));
    check("out_valid64", 64'(ov64), 64'(q64.size() > 0));
    if (q32.size() > 0) begin
      e = q32[0];
      check("imm32", 64'(imm32), e.imm);
      check("fmt32", 64'(fmt32), 64'(e.fmt));
      check("pc32", 64'(pc32), e.pc);
      check("tgt32", 64'(tgt32), e.tgt);
      check("ill32", 64'(ill32), 64'(e.ill));
    end
    if (q64.size() > 0) begin
      e = q64[0];
      check("imm64", imm64, e.imm);
      check("fmt64", 64'(fmt64), 64'(e.fmt));
      check("pc64", pc64, e.pc);
      check("tgt64", tgt64, e.tgt);
      check("ill64", 64'(ill64), 64'(e.ill));
    end
  endtask

  task automatic model_edge(input logic v, input logic [31:0] ins,
                            input logic [63:0] pc, input logic ordy,
                            input logic fl);
    logic acc;
    acc = v && ready_m;
    if (fl) begin
      q32.delete();
      q64.delete();
      ready_m = 1'b1;
    end else begin
      if (q32.size() > 0 && ordy) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (acc) begin
        q32.push_back(ref_dec(ins, pc, 1'b0));
        q64.push_back(ref_dec(ins, pc, 1'b1));
      end
      ready_m = (q32.size() != 2);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins,
                      input logic [63:0] pc, input logic ordy,
                      input logic fl);
    check_outs();
    in_valid  = v;
    in_inst   = ins;
    in_pc64   = pc;
    in_pc32   = pc[31:0];
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_edge(v, ins, pc, ordy, fl);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
  endtask

  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                           7'h63, 7'h6F, 7'h37, 7'h17, 7'h73};

  initial begin
    logic [31:0] ins;
    int k;
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_inst = '0;
    in_pc32 = '0;
    in_pc64 = '0;
    ready_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(ov32), 64'h0);
    check("rst_ready", 64'(rdy32), 64'h1);
    check("rst_imm", 64'(imm32), 64'h0);
    check("rst_fmt", 64'(fmt32), 64'h0);
    check("rst_pc", 64'(pc32), 64'h0);
    check("rst_tgt", 64'(tgt32), 64'h0);
    check("rst_ill", 64'(ill32), 64'h0);
    check("rst_valid64", 64'(ov64), 64'h0);
    reset = 1'b0;

    step(1'b1, 32'hFFF00093, 64'h100, 1'b1, 1'b0);
    check("addi_valid", 64'(ov32), 64'h1);
    check("addi_imm", 64'(imm32), 64'hFFFFFFFF);
    check("addi_fmt", 64'(fmt32), 64'd1);
    check("addi_tgt", 64'(tgt32), 64'hFF);
    step(1'b1, 32'h4030D093, 64'h104, 1'b1, 1'b0);
    check("srai_imm", 64'(imm32), 64'h3);
    check("srai_fmt", 64'(fmt32), 64'd6);
    step(1'b1, 32'hFE000EE3, 64'h200, 1'b1, 1'b0);
    check("beq_imm", 64'(imm32), 64'hFFFFFFFC);
    check("beq_fmt", 64'(fmt32), 64'd3);
    check("beq_tgt", 64'(tgt32), 64'h1FC);
    step(1'b1, 32'h80000037, 64'h0, 1'b1, 1'b0);
    check("lui64_imm", imm64, 64'hFFFFFFFF80000000);
    check("lui64_fmt", 64'(fmt64), 64'd4);
    step(1'b1, 32'h03F09093, 64'h0, 1'b1, 1'b0);
    check("slli63_imm", imm64, 64'd63);
    check("slli63_ill32", 64'(ill32), 64'(ILL_ON));
    step(1'b1, 32'h0000007F, 64'h0, 1'b1, 1'b0);
    check("unk_ill64", 64'(ill64), 64'(ILL_ON));
    check("unk_fmt", 64'(fmt64), 64'd0);
    idle(2);

    step(1'b1, 32'h00100093, 64'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 64'h304, 1'b0, 1'b0);
    check("bp_ready", 64'(rdy32), 64'h0);
    step(1'b1, 32'h00300093, 64'h308, 1'b0, 1'b0);
    check("bp_hold_a", 64'(imm32), 64'h1);
    step(1'b1, 32'h00300093, 64'h308, 1'b1, 1'b0);
    check("bp_b", 64'(imm32), 64'h2);
    step(1'b1, 32'h00300093, 64'h308, 1'b1, 1'b0);
    check("bp_c", 64'(imm32), 64'h3);
    idle(2);

    step(1'b1, 32'h00100093, 64'h400, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 64'h404, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 64'h408, 1'b1, 1'b1);
    check("fl_valid", 64'(ov32), 64'h0);
    check("fl_ready", 64'(rdy32), 64'h1);
    idle(2);
    step(1'b1, 32'h00500093, 64'h500, 1'b0, 1'b0);
    step(1'b1, 32'h00600093, 64'h504, 1'b1, 1'b1);
    check("fl_acc_valid", 64'(ov32), 64'h0);
    idle(2);

    step(1'b1, 32'h00700093, 64'h600, 1'b0, 1'b0);
    step(1'b1, 32'h00800093, 64'h604, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 64'(ov32), 64'h0);
    check("arst_ready", 64'(rdy32), 64'h1);
    check("arst_imm", 64'(imm32), 64'h0);
    check("arst_tgt", 64'(tgt32), 64'h0);
    check("arst_valid64", 64'(ov64), 64'h0);
    q32.delete();
    q64.delete();
    ready_m = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle(1);

    for (int i = 0; i < 600; i++) begin
      ins = $urandom();
      k = $urandom_range(0, 10);
      if (k < 10) ins[6:0] = ops[k];
      step($urandom_range(0, 9) < 7, ins,
           {$urandom(), $urandom()},
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
